// File: rtl/fifo_stream_framer.sv
// fifo_stream_framer: pops a fall-through FIFO and re-emits words as a packetised valid/ready stream
// Ports: rd_clk/rd_rst_n (read clock, async active-low reset), enable (stream on/off),
//        fifo_rd_data/fifo_empty/fifo_rd_en (FIFO read side), m_data/m_valid/m_last/m_ready
//        (output stream, m_last on every PKT_LEN-th word), busy, underrun/underrun_count/underrun_clr
//        (in-packet starvation status).
module fifo_stream_framer #(
  parameter int DATA_WIDTH = 16,
  parameter int PKT_LEN    = 16
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic                  underrun,
  output logic [15:0]           underrun_count,
  input  logic                  underrun_clr
);
  localparam int CW = $clog2(PKT_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(PKT_LEN - 1);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            r_occ;
  logic [CW-1:0]         r_pop_cnt;
  logic [DATA_WIDTH-1:0] r_data [2];
  logic [1:0]            r_last;
  logic                  r_underrun;
  logic [15:0]           r_ucnt;

  logic                  w_hs;
  logic                  w_pop_last;
  logic                  w_wr_idx;
  logic                  w_event;
  logic [CW-1:0]         w_cnt_nxt;
  logic [1:0]            w_state_nxt;

  // Pop decision uses only registered state and fifo_empty, never m_ready.
  assign fifo_rd_en = (r_state != IDLE) && !fifo_empty && (r_occ != 2'd2);
  assign w_pop_last = r_pop_cnt == CNT_LAST;
  assign w_hs       = m_valid && m_ready;
  // A popped word lands behind whatever survives this cycle's handshake.
  assign w_wr_idx   = r_occ[0] && !w_hs;
  assign w_cnt_nxt  = !fifo_rd_en ? r_pop_cnt : w_pop_last ? '0 : r_pop_cnt + CW'(1);
  assign w_event    = (r_state != IDLE) && (r_pop_cnt != '0) && fifo_empty && (r_occ == 2'd0);

  // Stop decisions look at the post-pop count so a pop in the same cycle
  // as enable falling can never leave a packet cut short.
  assign w_state_nxt = (r_state == IDLE)   ? (enable ? STREAM : IDLE) :
                       (r_state == STREAM) ? (enable ? STREAM : (w_cnt_nxt == '0) ? IDLE : DRAIN) :
                       (fifo_rd_en && w_pop_last) ? IDLE : DRAIN;

  assign m_valid        = r_occ != 2'd0;
  assign m_data         = r_data[0];
  assign m_last         = r_last[0];
  assign busy           = (r_state != IDLE) || m_valid;
  assign underrun       = r_underrun;
  assign underrun_count = r_ucnt;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_state    <= IDLE;
      r_occ      <= 2'd0;
      r_pop_cnt  <= '0;
      r_data[0]  <= '0;
      r_data[1]  <= '0;
      r_last     <= 2'b00;
      r_underrun <= 1'b0;
      r_ucnt     <= 16'h0000;
    end else begin
      r_state   <= w_state_nxt;
      r_pop_cnt <= w_cnt_nxt;
      r_occ     <= r_occ + {1'b0, fifo_rd_en} - {1'b0, w_hs};
      if (w_hs) begin
        r_data[0] <= r_data[1];
        r_last[0] <= r_last[1];
      end
      if (fifo_rd_en) begin
        r_data[w_wr_idx] <= fifo_rd_data;
        r_last[w_wr_idx] <= w_pop_last;
      end
      if (underrun_clr) begin
        r_underrun <= 1'b0;
        r_ucnt     <= 16'h0000;
      end else if (w_event) begin
        r_underrun <= 1'b1;
        if (r_ucnt != 16'hFFFF) r_ucnt <= r_ucnt + 16'h0001;
      end
    end
  end
endmodule

// File: tb/tb_fifo_stream_framer.sv
// tb_fifo_stream_framer: directed self-checking bench for fifo_stream_framer
module tb_fifo_stream_framer;
  localparam int DW = 16;
  localparam int PL = 16;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          underrun;
  logic [15:0]   underrun_count;
  logic          underrun_clr = 1'b0;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] got_d[$];
  logic          got_l[$];
  int            got_t[$];
  int cyc_n = 0;
  int pops = 0;
  int occ_m = 0;
  int viol = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_d = '0;
  logic prev_l = 1'b0;
  logic busy_at_last = 1'b0;

  fifo_stream_framer #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
    .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .enable(enable),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .underrun(underrun), .underrun_count(underrun_count),
    .underrun_clr(underrun_clr)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic refresh();
    fifo_empty = (q.size() == 0);
    fifo_rd_data = fifo_empty ? '0 : q[0];
  endtask

  task automatic push_range(input int a, input int b);
    for (int i = a; i <= b; i++) q.push_back(DW'(i));
    refresh();
  endtask

  task automatic cyc();
    logic p, h, l;
    logic [DW-1:0] d;
    @(negedge rd_clk);
    p = fifo_rd_en;
    h = m_valid && m_ready;
    d = m_data;
    l = m_last;
    if (prev_stall && (!m_valid || m_data !== prev_d || m_last !== prev_l)) viol++;
    if (occ_m > 2 || (p && occ_m == 2) || m_valid !== (occ_m != 0)) viol++;
    prev_stall = m_valid && !m_ready;
    prev_d = d;
    prev_l = l;
    if (h && l) busy_at_last = busy;
    @(posedge rd_clk);
    cyc_n++;
    if (p && q.size() > 0) begin
      void'(q.pop_front());
      pops++;
    end
    if (h) begin
      got_d.push_back(d);
      got_l.push_back(l);
      got_t.push_back(cyc_n);
    end
    occ_m = occ_m + int'(p) - int'(h);
    #1 refresh();
  endtask

  task automatic run_until(input int n, input int budget);
    int k = 0;
    while (got_d.size() < n && k < budget) begin
      cyc();
      k++;
    end
  endtask

  task automatic do_reset();
    rd_rst_n = 1'b0;
    enable = 1'b0;
    m_ready = 1'b0;
    underrun_clr = 1'b0;
    q.delete();
    refresh();
    got_d.delete();
    got_l.delete();
    got_t.delete();
    occ_m = 0;
    pops = 0;
    viol = 0;
    prev_stall = 1'b0;
    busy_at_last = 1'b0;
    repeat (2) @(posedge rd_clk);
    #1 rd_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rd_rst_n = 1'b0;
    push_range(1, 4);
    #3;
    tests++;
    if ({fifo_rd_en, m_valid, m_last, busy, underrun} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags got=%b required=00000", {fifo_rd_en, m_valid, m_last, busy, underrun});
    end
    tests++;
    if (m_data !== '0) begin fails++; $display("FAIL reset_data got=%h required=0000", m_data); end
    tests++;
    if (underrun_count !== 16'h0) begin fails++; $display("FAIL reset_ucnt got=%h required=0000", underrun_count); end
    #20 rd_rst_n = 1'b1;
    cyc();
    tests++;
    if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL idle_no_pop got=%b required=0", fifo_rd_en); end
  endtask

  task automatic test_stream();
    int start, bad, gaps;
    do_reset();
    push_range(1, 32);
    start = cyc_n;
    enable = 1'b1;
    m_ready = 1'b1;
    run_until(32, 80);
    tests++;
    if (got_d.size() != 32) begin fails++; $display("FAIL stream_count got=%0d required=32", got_d.size()); end
    bad = 0;
    for (int i = 0; i < got_d.size(); i++)
      if (got_d[i] !== DW'(i + 1) || got_l[i] !== (i == 15 || i == 31)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL stream_words bad=%0d required=0", bad); end
    tests++;
    if (got_t.size() == 0 || got_t[0] != start + 3) begin
      fails++;
      $display("FAIL stream_latency got=%0d required=%0d", got_t.size() == 0 ? -1 : got_t[0] - start, 3);
    end
    gaps = 0;
    for (int i = 1; i < got_t.size(); i++) if (got_t[i] != got_t[i-1] + 1) gaps++;
    tests++;
    if (gaps != 0) begin fails++; $display("FAIL stream_rate gaps=%0d required=0", gaps); end
    tests++;
    if (underrun_count !== 16'h0) begin fails++; $display("FAIL stream_ucnt got=%0d required=0", underrun_count); end
    enable = 1'b0;
    repeat (3) cyc();
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL stream_busy got=%b required=0", busy); end
  endtask

  task automatic test_stall();
    int k, bad;
    do_reset();
    push_range(1, 32);
    enable = 1'b1;
    m_ready = 1'b1;
    k = 0;
    while (got_d.size() < 32 && k < 200) begin
      cyc();
      m_ready = ~m_ready;
      k++;
    end
    tests++;
    if (got_d.size() != 32) begin fails++; $display("FAIL stall_count got=%0d required=32", got_d.size()); end
    bad = 0;
    for (int i = 0; i < got_d.size(); i++)
      if (got_d[i] !== DW'(i + 1) || got_l[i] !== (i == 15 || i == 31)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL stall_words bad=%0d required=0", bad); end
    tests++;
    if (viol != 0) begin fails++; $display("FAIL stall_hold_occ violations=%0d required=0", viol); end
    enable = 1'b0;
  endtask

  task automatic test_drain();
    int k, bad;
    do_reset();
    push_range(1, 20);
    enable = 1'b1;
    m_ready = 1'b1;
    k = 0;
    while (pops < 5 && k < 20) begin
      cyc();
      k++;
    end
    enable = 1'b0;
    run_until(16, 60);
    repeat (5) cyc();
    tests++;
    if (got_d.size() != 16 || pops != 16) begin
      fails++;
      $display("FAIL drain_count got=%0d/%0d required=16/16", got_d.size(), pops);
    end
    bad = 0;
    for (int i = 0; i < got_d.size(); i++)
      if (got_d[i] !== DW'(i + 1) || got_l[i] !== (i == 15)) bad++;
    tests++;
    if (bad != 0) begin fails++; $display("FAIL drain_words bad=%0d required=0", bad); end
    tests++;
    if (q.size() != 4) begin fails++; $display("FAIL drain_fifo_left got=%0d required=4", q.size()); end
    tests++;
    if (busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL drain_idle busy=%b rd_en=%b required=0/0", busy, fifo_rd_en);
    end
    tests++;
    if (busy_at_last !== 1'b1) begin fails++; $display("FAIL drain_busy_last got=%b required=1", busy_at_last); end
    tests++;
    if (viol != 0) begin fails++; $display("FAIL drain_protocol violations=%0d required=0", viol); end
  endtask

  task automatic test_underrun();
    int bad;
    do_reset();
    push_range(1, 7);
    enable = 1'b1;
    m_ready = 1'b1;
    run_until(7, 30);
    repeat (10) cyc();
    tests++;
    if (underrun !== 1'b1 || underrun_count !== 16'd10) begin
      fails++;
      $display("FAIL underrun_set flag=%b count=%0d required=1/10", underrun, underrun_count);
    end
    push_range(8, 16);
    run_until(16, 40);
    bad = 0;
    for (int i = 0; i < got_d.size(); i++)
      if (got_d[i] !== DW'(i + 1) || got_l[i] !== (i == 15)) bad++;
    tests++;
    if (got_d.size() != 16 || bad != 0) begin
      fails++;
      $display("FAIL underrun_resume count=%0d bad=%0d required=16/0", got_d.size(), bad);
    end
    tests++;
    if (underrun_count !== 16'd10) begin fails++; $display("FAIL underrun_hold got=%0d required=10", underrun_count); end
    underrun_clr = 1'b1;
    cyc();
    underrun_clr = 1'b0;
    tests++;
    if (underrun !== 1'b0 || underrun_count !== 16'd0) begin
      fails++;
      $display("FAIL underrun_clr flag=%b count=%0d required=0/0", underrun, underrun_count);
    end
  endtask

  task automatic test_boundary();
    repeat (50) cyc();
    tests++;
    if (underrun !== 1'b0 || underrun_count !== 16'd0) begin
      fails++;
      $display("FAIL boundary_starve flag=%b count=%0d required=0/0", underrun, underrun_count);
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k, bad;
    do_reset();
    push_range(1, 20);
    enable = 1'b1;
    m_ready = 1'b0;
    k = 0;
    while (occ_m < 2 && k < 20) begin
      cyc();
      k++;
    end
    tests++;
    if (m_valid !== 1'b1 || occ_m != 2) begin
      fails++;
      $display("FAIL rstmid_fill valid=%b occ=%0d required=1/2", m_valid, occ_m);
    end
    rd_rst_n = 1'b0;
    #1;
    tests++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_async valid=%b busy=%b required=0/0", m_valid, busy);
    end
    #2 rd_rst_n = 1'b1;
    got_d.delete();
    got_l.delete();
    got_t.delete();
    occ_m = 0;
    prev_stall = 1'b0;
    m_ready = 1'b1;
    run_until(16, 60);
    bad = 0;
    for (int i = 0; i < got_d.size(); i++)
      if (got_d[i] !== DW'(i + 3) || got_l[i] !== (i == 15)) bad++;
    tests++;
    if (got_d.size() != 16 || bad != 0) begin
      fails++;
      $display("FAIL rstmid_restart count=%0d bad=%0d required=16/0", got_d.size(), bad);
    end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_drain();
    test_underrun();
    test_boundary();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end
endmodule
